// File: rtl/audio_mixer_nch.sv
// Time-multiplexed N-channel stereo mixer: one channel per clock into wide accumulators,
// then master attenuation, crossfeed and saturation into a held valid/ready output word.
module audio_mixer_nch #(
    parameter int NCH = 4,
    parameter int DW  = 16,
    parameter int GW  = 8,
    parameter int OW  = 16
) (
    input  logic                  clk_audio,
    input  logic                  reset_n,
    input  logic                  sample_stb,
    input  logic [NCH*DW-1:0]     ch_l,
    input  logic [NCH*DW-1:0]     ch_r,
    input  logic [NCH-1:0]        ch_signed,
    input  logic [NCH*GW-1:0]     ch_gain,
    input  logic [NCH*2-1:0]      ch_route,
    input  logic [3:0]            vol_att,
    input  logic [1:0]            mix,
    output logic signed [OW-1:0]  out_l,
    output logic signed [OW-1:0]  out_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  clip_l,
    output logic                  clip_r,
    output logic [7:0]            overrun_cnt,
    input  logic                  stat_clr
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = DW + GW + 1;
    localparam int AW = DW + GW + $clog2(NCH) + 1;
    localparam int XW = AW + 4;
    localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {ST_IDLE, ST_ACCUM, ST_SCALE, ST_SAT, ST_HOLD} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [NCH*DW-1:0]      r_ch_l, r_ch_r;
    logic [NCH-1:0]         r_signed;
    logic [NCH*GW-1:0]      r_gain;
    logic [NCH*2-1:0]       r_route;
    logic [3:0]             r_vol_att;
    logic [1:0]             r_mix;
    logic signed [AW-1:0]   r_acc_l, r_acc_r;
    logic signed [XW-1:0]   r_xl, r_xr;
    logic signed [OW-1:0]   r_out_l, r_out_r;
    logic                   r_valid;
    logic                   r_clip_l, r_clip_r;
    logic [7:0]             r_ovr;

    logic signed [PW-1:0]   w_prod_l [NCH];
    logic signed [PW-1:0]   w_prod_r [NCH];
    logic [NCH-1:0]         w_rt_l, w_rt_r;
    logic signed [XW-1:0]   w_sl, w_sr, w_xl, w_xr;
    logic                   w_ovr, w_clip_l, w_clip_r;

    // Offset-binary samples become two's complement by flipping the MSB.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic signed [DW-1:0] w_l, w_r;
        assign w_l = r_signed[gi] ? r_ch_l[gi*DW +: DW]
                                  : {~r_ch_l[gi*DW+DW-1], r_ch_l[gi*DW +: DW-1]};
        assign w_r = r_signed[gi] ? r_ch_r[gi*DW +: DW]
                                  : {~r_ch_r[gi*DW+DW-1], r_ch_r[gi*DW +: DW-1]};
        assign w_prod_l[gi] = PW'(w_l) * PW'($signed({1'b0, r_gain[gi*GW +: GW]}));
        assign w_prod_r[gi] = PW'(w_r) * PW'($signed({1'b0, r_gain[gi*GW +: GW]}));
        assign w_rt_l[gi]   = r_route[2*gi];
        assign w_rt_r[gi]   = r_route[2*gi+1];
    end

    always_comb begin
        w_sl = (XW'(r_acc_l) >>> (GW-1)) >>> r_vol_att;
        w_sr = (XW'(r_acc_r) >>> (GW-1)) >>> r_vol_att;
        if (&r_vol_att) begin
            w_sl = '0;
            w_sr = '0;
        end
        case (r_mix)
            2'd1: begin
                w_xl = ((w_sl <<< 1) + w_sl + w_sr) >>> 2;
                w_xr = ((w_sr <<< 1) + w_sr + w_sl) >>> 2;
            end
            2'd2: begin
                w_xl = ((w_sl <<< 2) + w_sl + (w_sr <<< 1) + w_sr) >>> 3;
                w_xr = ((w_sr <<< 2) + w_sr + (w_sl <<< 1) + w_sl) >>> 3;
            end
            2'd3: begin
                w_xl = (w_sl + w_sr) >>> 1;
                w_xr = w_xl;
            end
            default: begin
                w_xl = w_sl;
                w_xr = w_sr;
            end
        endcase
    end

    function automatic logic signed [OW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > MAXV)      return MAXV[OW-1:0];
        else if (v < MINV) return MINV[OW-1:0];
        else               return v[OW-1:0];
    endfunction

    assign w_ovr    = sample_stb && (r_state != ST_IDLE);
    assign w_clip_l = (r_state == ST_SAT) && ((r_xl > MAXV) || (r_xl < MINV));
    assign w_clip_r = (r_state == ST_SAT) && ((r_xr > MAXV) || (r_xr < MINV));

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_ch_l    <= '0;
            r_ch_r    <= '0;
            r_signed  <= '0;
            r_gain    <= '0;
            r_route   <= '0;
            r_vol_att <= '0;
            r_mix     <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_xl      <= '0;
            r_xr      <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (sample_stb) begin
                    r_ch_l    <= ch_l;
                    r_ch_r    <= ch_r;
                    r_signed  <= ch_signed;
                    r_gain    <= ch_gain;
                    r_route   <= ch_route;
                    r_vol_att <= vol_att;
                    r_mix     <= mix;
                    r_acc_l   <= '0;
                    r_acc_r   <= '0;
                    r_idx     <= '0;
                    r_state   <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (w_rt_l[r_idx]) r_acc_l <= r_acc_l + AW'(w_prod_l[r_idx]);
                    if (w_rt_r[r_idx]) r_acc_r <= r_acc_r + AW'(w_prod_r[r_idx]);
                    if (r_idx == IW'(NCH-1)) r_state <= ST_SCALE;
                    else                     r_idx   <= r_idx + 1'b1;
                end
                ST_SCALE: begin
                    r_xl    <= w_xl;
                    r_xr    <= w_xr;
                    r_state <= ST_SAT;
                end
                ST_SAT: begin
                    r_out_l <= sat(r_xl);
                    r_out_r <= sat(r_xr);
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A set event in the same cycle as stat_clr takes priority over the clear.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
            r_ovr    <= '0;
        end else begin
            r_clip_l <= w_clip_l | (r_clip_l & ~stat_clr);
            r_clip_r <= w_clip_r | (r_clip_r & ~stat_clr);
            if (stat_clr)                       r_ovr <= w_ovr ? 8'd1 : 8'd0;
            else if (w_ovr && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
        end
    end

    assign out_l       = r_out_l;
    assign out_r       = r_out_r;
    assign out_valid   = r_valid;
    assign busy        = (r_state != ST_IDLE);
    assign clip_l      = r_clip_l;
    assign clip_r      = r_clip_r;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Scoreboard bench for audio_mixer_nch: directed frames from the test plan plus randomized
// frames, each checked against an integer reference model when the DUT transfers its word.
module tb_audio_mixer_nch;
    localparam int NCH = 4, DW = 16, GW = 8, OW = 16;

    logic                 clk_audio = 1'b0;
    logic                 reset_n, sample_stb, out_ready, stat_clr;
    logic [NCH*DW-1:0]    ch_l, ch_r;
    logic [NCH-1:0]       ch_signed;
    logic [NCH*GW-1:0]    ch_gain;
    logic [NCH*2-1:0]     ch_route;
    logic [3:0]           vol_att;
    logic [1:0]           mix;
    logic signed [OW-1:0] out_l, out_r;
    logic                 out_valid, busy, clip_l, clip_r;
    logic [7:0]           overrun_cnt;

    always #5 clk_audio = ~clk_audio;

    audio_mixer_nch #(.NCH(NCH), .DW(DW), .GW(GW), .OW(OW)) dut (
        .clk_audio(clk_audio), .reset_n(reset_n), .sample_stb(sample_stb),
        .ch_l(ch_l), .ch_r(ch_r), .ch_signed(ch_signed), .ch_gain(ch_gain),
        .ch_route(ch_route), .vol_att(vol_att), .mix(mix),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .clip_l(clip_l), .clip_r(clip_r), .overrun_cnt(overrun_cnt),
        .stat_clr(stat_clr)
    );

    typedef struct { longint l; longint r; bit cl; bit cr; } exp_t;
    exp_t q[$];

    int n_chk = 0, n_pass = 0;
    int cfg_l[NCH], cfg_r[NCH], cfg_g[NCH];
    bit cfg_s[NCH];
    bit [1:0] cfg_rt[NCH];
    int cfg_att, cfg_mix;
    bit m_clip_l, m_clip_r;
    int m_ovr;
    bit ready_rand = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    function automatic longint to_val(input int raw, input bit is_signed);
        if (is_signed) return (raw >= 32768) ? raw - 65536 : raw;
        return raw - 32768;
    endfunction

    function automatic longint clampv(input longint v, output bit clipped);
        clipped = 1'b1;
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        clipped = 1'b0;
        return v;
    endfunction

    // Reference: exact integer sum of gain-weighted samples, then scaling/crossfeed/clamp.
    task automatic model_push();
        longint al = 0, ar = 0, l, r, ol, orr;
        exp_t e;
        bit el, er;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_rt[k][0]) al += to_val(cfg_l[k], cfg_s[k]) * cfg_g[k];
            if (cfg_rt[k][1]) ar += to_val(cfg_r[k], cfg_s[k]) * cfg_g[k];
        end
        l = al >>> (GW-1);
        r = ar >>> (GW-1);
        if (cfg_att == 15) begin l = 0; r = 0; end
        else begin l = l >>> cfg_att; r = r >>> cfg_att; end
        case (cfg_mix)
            1: begin ol = (3*l + r) >>> 2;   orr = (3*r + l) >>> 2;   end
            2: begin ol = (5*l + 3*r) >>> 3; orr = (5*r + 3*l) >>> 3; end
            3: begin ol = (l + r) >>> 1;     orr = ol;                end
            default: begin ol = l; orr = r; end
        endcase
        e.l = clampv(ol, el);
        e.r = clampv(orr, er);
        m_clip_l |= el;
        m_clip_r |= er;
        e.cl = m_clip_l;
        e.cr = m_clip_r;
        q.push_back(e);
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            ch_l[k*DW +: DW]     = cfg_l[k][DW-1:0];
            ch_r[k*DW +: DW]     = cfg_r[k][DW-1:0];
            ch_signed[k]         = cfg_s[k];
            ch_gain[k*GW +: GW]  = cfg_g[k][GW-1:0];
            ch_route[k*2 +: 2]   = cfg_rt[k];
        end
        vol_att = cfg_att[3:0];
        mix     = cfg_mix[1:0];
    endtask

    task automatic set_default();
        for (int k = 0; k < NCH; k++) begin
            cfg_l[k] = 0; cfg_r[k] = 0; cfg_g[k] = 128; cfg_s[k] = 1; cfg_rt[k] = 2'b11;
        end
        cfg_att = 0;
        cfg_mix = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_audio);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk_audio);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Returns at the negedge following the capture edge.
    task automatic start_frame(input bit expect_out);
        wait_idle();
        drive();
        if (expect_out) model_push();
        sample_stb = 1'b1;
        @(negedge clk_audio);
        sample_stb = 1'b0;
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(negedge clk_audio);
        stat_clr = 1'b0;
        m_clip_l = 0;
        m_clip_r = 0;
        m_ovr    = 0;
    endtask

    // Monitor: pops on every transfer and checks that a stalled word stays put.
    initial begin : monitor
        bit hold = 0;
        logic signed [OW-1:0] hl, hr;
        exp_t e;
        forever begin
            @(negedge clk_audio);
            #1;
            if (reset_n !== 1'b1) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_l", out_l, hl);
                    check("hold_r", out_r, hr);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_output: got l=%0d r=%0d, required no transfer", out_l, out_r);
                    end else begin
                        e = q.pop_front();
                        check("out_l", out_l, e.l);
                        check("out_r", out_r, e.r);
                        check("clip_l", clip_l, e.cl);
                        check("clip_r", clip_r, e.cr);
                    end
                    hold = 0;
                end else if (out_valid) begin
                    hold = 1; hl = out_l; hr = out_r;
                end else begin
                    hold = 0;
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(negedge clk_audio);
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        reset_n = 1'b0; sample_stb = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        set_default();
        drive();
        m_clip_l = 0; m_clip_r = 0; m_ovr = 0;
        repeat (3) @(negedge clk_audio);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_l", out_l, 0);
        check("rst_ovr", overrun_cnt, 0);
        reset_n = 1'b1;

        // Single channel at unity gain, with latency measurement.
        set_default();
        cfg_l[0] = 1000;
        wait_idle();
        drive();
        model_push();
        sample_stb = 1'b1;
        @(posedge clk_audio);
        n = 1;
        @(negedge clk_audio);
        sample_stb = 1'b0;
        check("busy_rise", busy, 1);
        while (!out_valid && n < 50) begin
            @(posedge clk_audio);
            n++;
            @(negedge clk_audio);
        end
        check("latency", n, 7);

        // Four hot channels at full gain saturate the left bus only.
        set_default();
        for (int k = 0; k < NCH; k++) begin cfg_l[k] = 'h7000; cfg_g[k] = 255; end
        start_frame(1);
        wait_idle();
        check("clip_l_set", clip_l, 1);
        pulse_clr();
        check("clip_l_clr", clip_l, 0);

        // Offset-binary midpoint and minimum.
        set_default();
        cfg_s[0] = 0; cfg_l[0] = 'h8000; cfg_r[0] = 'h8000;
        start_frame(1);
        cfg_l[0] = 0;
        start_frame(1);

        // Crossfeed modes and mute.
        set_default();
        cfg_l[0] = 4000; cfg_mix = 3;
        start_frame(1);
        cfg_mix = 1;
        start_frame(1);
        cfg_mix = 2;
        start_frame(1);
        cfg_att = 15;
        start_frame(1);

        // Stalled output with strobes while holding, then a strobe on the completing cycle.
        wait_idle();
        pulse_clr();
        set_default();
        cfg_l[1] = -1234; cfg_r[2] = 777; cfg_rt[3] = 2'b00; cfg_l[3] = 9999;
        out_ready = 1'b0;
        start_frame(1);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk_audio); n++; end
        check("hold_reached", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            sample_stb = (i == 3 || i == 8 || i == 15);
            @(negedge clk_audio);
        end
        sample_stb = 1'b0;
        check("ovr_three", overrun_cnt, 3);
        check("still_valid", out_valid, 1);
        out_ready = 1'b1;
        sample_stb = 1'b1;
        @(negedge clk_audio);
        sample_stb = 1'b0;
        check("valid_fall", out_valid, 0);
        check("idle_after_xfer", busy, 0);
        check("ovr_complete_cycle", overrun_cnt, 4);
        m_ovr = 4;
        // Clear and overrun in the same cycle leaves a count of one.
        start_frame(1);
        stat_clr = 1'b1; sample_stb = 1'b1;
        @(negedge clk_audio);
        stat_clr = 1'b0; sample_stb = 1'b0;
        check("ovr_clr_set", overrun_cnt, 1);
        m_ovr = 1;

        // Reset in the middle of accumulation aborts the frame.
        set_default();
        cfg_l[2] = 5555;
        start_frame(0);
        @(negedge clk_audio);
        @(negedge clk_audio);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        m_clip_l = 0; m_clip_r = 0; m_ovr = 0;
        @(negedge clk_audio);
        reset_n = 1'b1;
        repeat (15) @(negedge clk_audio);
        check("abort_no_valid", out_valid, 0);
        start_frame(1);

        // Randomized frames with random backpressure, extra strobes and mid-frame bus changes.
        ready_rand = 1;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < NCH; k++) begin
                cfg_l[k]  = $urandom_range(0, 65535);
                cfg_r[k]  = $urandom_range(0, 65535);
                cfg_g[k]  = $urandom_range(0, 255);
                cfg_s[k]  = 1'($urandom_range(0, 1));
                cfg_rt[k] = 2'($urandom_range(0, 3));
            end
            cfg_att = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 6);
            cfg_mix = $urandom_range(0, 3);
            start_frame(1);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk_audio);
                ch_l = {NCH{16'($urandom)}};
                ch_gain = {NCH{8'($urandom)}};
                sample_stb = 1'b1;
                @(negedge clk_audio);
                sample_stb = 1'b0;
                m_ovr++;
            end
        end
        ready_rand = 0;
        out_ready = 1'b1;
        wait_idle();
        check("ovr_random", overrun_cnt, (m_ovr > 255) ? 255 : m_ovr);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
